// File: rtl/eth_frame_checker_pkg.sv
// Shared types and constants for the Ethernet receive frame checker.
// The CRC constants are also used by the upstream frame generator.
package eth_chk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

endpackage

// File: rtl/eth_frame_checker_if.sv
// Receive byte stream in, checked post-SFD byte stream out.
interface eth_frame_checker_if;

    logic [7:0] rxd;
    logic       rx_dv;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sof;
    logic       out_eof;
    logic       out_err;

    modport master (
        output rxd, rx_dv,
        input  out_data, out_valid, out_sof, out_eof, out_err
    );

    modport slave (
        input  rxd, rx_dv,
        output out_data, out_valid, out_sof, out_eof, out_err
    );

endinterface

// File: rtl/eth_frame_checker_crc.sv
// Combinational CRC-32 update for one byte (reflected polynomial, LSB first).
module crc32_d8
    import eth_chk_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = (crc_out >> 1) ^ ((crc_out[0] ^ d[i]) ? CRC_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/eth_frame_checker.sv
// Receive checker: validates preamble/SFD, strips it, forwards the frame with
// sof/eof markers, checks FCS and length, and keeps saturating frame statistics.
module eth_frame_checker
    import eth_chk_pkg::*;
#(
    parameter int PRE_MIN = 3,
    parameter int PRE_MAX = 7,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eth_frame_checker_if.slave   bus,
    output logic [CNT_W-1:0]     ok_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     pre_err_cnt
);

    localparam int LEN_W  = $clog2(MAX_LEN + 2);
    localparam int PCNT_W = $clog2(PRE_MAX + 1);

    localparam logic [LEN_W-1:0]  LEN_SAT   = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]  MIN_LEN_C = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0]  MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [PCNT_W-1:0] PRE_MIN_C = PCNT_W'(PRE_MIN);
    localparam logic [PCNT_W-1:0] PRE_MAX_C = PCNT_W'(PRE_MAX);

    state_t            state_q, state_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d, pcnt_cur;
    logic [31:0]       crc_q, crc_d, crc_next;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              sof_pend_q, sof_pend_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sof_q, out_sof_d;
    logic              out_eof_q, out_eof_d;
    logic              out_err_q, out_err_d;
    logic [CNT_W-1:0]  ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  pre_err_cnt_q, pre_err_cnt_d;
    logic              ok_inc, err_inc, pre_inc, frame_bad;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .d       (bus.rxd),
        .crc_out (crc_next)
    );

    // IDLE evaluates its byte as the first preamble byte, so it sees a zero count
    assign pcnt_cur  = (state_q == IDLE) ? '0 : pcnt_q;
    assign frame_bad = (crc_q != CRC_RESIDUE) | (len_q < MIN_LEN_C) | (len_q > MAX_LEN_C);

    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        crc_d       = crc_q;
        len_d       = len_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        sof_pend_d  = sof_pend_q;
        out_data_d  = 8'h00;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        out_err_d   = 1'b0;
        ok_inc      = 1'b0;
        err_inc     = 1'b0;
        pre_inc     = 1'b0;

        unique case (state_q)
            IDLE, PREAMBLE: begin
                if (bus.rx_dv) begin
                    if (bus.rxd == PREAMBLE_BYTE && pcnt_cur < PRE_MAX_C) begin
                        pcnt_d  = pcnt_cur + PCNT_W'(1);
                        state_d = PREAMBLE;
                    end else if (bus.rxd == SFD_BYTE && pcnt_cur >= PRE_MIN_C) begin
                        state_d    = DATA;
                        crc_d      = CRC_INIT;
                        len_d      = '0;
                        hold_vld_d = 1'b0;
                        sof_pend_d = 1'b1;
                    end else begin
                        state_d = DROP;
                        pre_inc = 1'b1;
                    end
                end else if (state_q == PREAMBLE) begin
                    state_d = IDLE;
                    pre_inc = 1'b1;
                end
            end
            DATA: begin
                if (bus.rx_dv) begin
                    // One-byte hold delays output so the final byte can carry eof
                    if (hold_vld_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = hold_q;
                        out_sof_d   = sof_pend_q;
                        sof_pend_d  = 1'b0;
                    end
                    hold_d     = bus.rxd;
                    hold_vld_d = 1'b1;
                    crc_d      = crc_next;
                    len_d      = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);
                end else begin
                    state_d    = IDLE;
                    hold_vld_d = 1'b0;
                    if (hold_vld_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = hold_q;
                        out_sof_d   = sof_pend_q;
                        out_eof_d   = 1'b1;
                        out_err_d   = frame_bad;
                        ok_inc      = ~frame_bad;
                        err_inc     = frame_bad;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!bus.rx_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ok_cnt_d      = (ok_inc  && ok_cnt_q      != '1) ? ok_cnt_q      + CNT_W'(1) : ok_cnt_q;
        err_cnt_d     = (err_inc && err_cnt_q     != '1) ? err_cnt_q     + CNT_W'(1) : err_cnt_q;
        pre_err_cnt_d = (pre_inc && pre_err_cnt_q != '1) ? pre_err_cnt_q + CNT_W'(1) : pre_err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pcnt_q        <= '0;
            crc_q         <= '0;
            len_q         <= '0;
            hold_q        <= '0;
            hold_vld_q    <= 1'b0;
            sof_pend_q    <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_sof_q     <= 1'b0;
            out_eof_q     <= 1'b0;
            out_err_q     <= 1'b0;
            ok_cnt_q      <= '0;
            err_cnt_q     <= '0;
            pre_err_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            pcnt_q        <= pcnt_d;
            crc_q         <= crc_d;
            len_q         <= len_d;
            hold_q        <= hold_d;
            hold_vld_q    <= hold_vld_d;
            sof_pend_q    <= sof_pend_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_sof_q     <= out_sof_d;
            out_eof_q     <= out_eof_d;
            out_err_q     <= out_err_d;
            ok_cnt_q      <= ok_cnt_d;
            err_cnt_q     <= err_cnt_d;
            pre_err_cnt_q <= pre_err_cnt_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.out_err   = out_err_q;
    assign ok_cnt        = ok_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign pre_err_cnt   = pre_err_cnt_q;

endmodule
